// File: rtl/auth_resp_scheduler_pkg.sv
// Shared constants, state encoding and helpers for the
// authentication responder scheduler.
package auth_resp_scheduler_pkg;

    localparam int AUTH_MSG_LEN        = 64;
    localparam int AUTH_TIMEOUT_CYCLES = 1024;

    localparam logic [7:0] AUTH_VERSION     = 8'd1;
    localparam logic [7:0] MSG_TYPE_ERROR   = 8'd127;

    localparam logic [7:0] ERR_INVALID_REQUEST      = 8'd1;
    localparam logic [7:0] ERR_UNSUPPORTED_PROTOCOL = 8'd2;
    localparam logic [7:0] ERR_BUSY                 = 8'd3;
    localparam logic [7:0] ERR_UNSPECIFIED          = 8'd4;

    localparam int SIZE_OF_STATES_SCHED = 6;

    typedef enum logic [SIZE_OF_STATES_SCHED-1:0] {
        S_IDLE     = 6'b000001,
        S_ISSUE    = 6'b000010,
        S_WAIT_RSP = 6'b000100,
        S_RELEASE  = 6'b001000,
        S_TIMEOUT  = 6'b010000,
        S_DELIVER  = 6'b100000
    } sched_state_t;

    // Header vars are MSB-first: version, type, param1, param2.
    function automatic logic [31:0] err_header(input logic [7:0] code);
        return {AUTH_VERSION, MSG_TYPE_ERROR, code, 8'd0};
    endfunction

endpackage

// File: rtl/auth_resp_scheduler_rr_arbiter.sv
// Combinational rotate-priority picker: first set request
// at or after ptr, wrapping around.
module rr_arbiter #(
    parameter int N_REQ = 2,
    parameter int PW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [N_REQ-1:0] grant,
    output logic [PW-1:0]    idx,
    output logic             any
);

    always_comb begin
        int j;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        for (int k = 0; k < N_REQ; k++) begin
            j = int'(ptr) + k;
            if (j >= N_REQ) j = j - N_REQ;
            if (!any && req[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = PW'(j);
            end
        end
    end

endmodule

// File: rtl/auth_resp_scheduler.sv
// Shares one authentication responder among N_REQ ports with
// round-robin arbitration and a response timeout.
module auth_resp_scheduler
    import auth_resp_scheduler_pkg::*;
#(
    parameter int N_REQ          = 2,
    parameter int MSG_LEN        = AUTH_MSG_LEN,
    parameter int TIMEOUT_CYCLES = AUTH_TIMEOUT_CYCLES
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*MSG_LEN-1:0] req_msg,
    output logic [N_REQ-1:0]         req_ready,
    output logic [N_REQ-1:0]         rsp_valid,
    output logic [MSG_LEN-1:0]       rsp_msg,
    input  logic [N_REQ-1:0]         rsp_ack,
    output logic                     resp_req_in,
    output logic [MSG_LEN-1:0]       auth_msg_resp_in,
    output logic                     Ack_in,
    output logic                     resp_reset,
    input  logic                     resp_req_out,
    input  logic [MSG_LEN-1:0]       auth_msg_resp_out,
    output logic                     busy,
    output logic [7:0]               timeout_count
);

    localparam int PW = $clog2(N_REQ);
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [MSG_LEN-1:0] ERR_MSG =
        {err_header(ERR_UNSPECIFIED), {(MSG_LEN-32){1'b0}}};

    sched_state_t state_q, state_d;

    logic [PW-1:0]      rr_ptr_q, rr_ptr_d, g_q, g_d;
    logic [MSG_LEN-1:0] msg_q, msg_d, cap_q, cap_d;
    logic [MSG_LEN-1:0] rsp_msg_d, amsg_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [7:0]         tcnt_d;
    logic [N_REQ-1:0]   req_ready_d, rsp_valid_d;
    logic               resp_req_in_d, ack_d, rreset_d, busy_d;

    logic [N_REQ-1:0] arb_grant;
    logic [PW-1:0]    arb_idx;
    logic             arb_any;

    rr_arbiter #(.N_REQ(N_REQ), .PW(PW)) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr_q),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        g_d         = g_q;
        msg_d       = msg_q;
        cap_d       = cap_q;
        timer_d     = timer_q;
        tcnt_d      = timeout_count;
        rsp_msg_d   = rsp_msg;
        amsg_d      = auth_msg_resp_in;
        req_ready_d = '0;
        ack_d       = 1'b0;
        rreset_d    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (arb_any) begin
                    state_d     = S_ISSUE;
                    g_d         = arb_idx;
                    msg_d       = req_msg[int'(arb_idx)*MSG_LEN +: MSG_LEN];
                    req_ready_d = arb_grant;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT_RSP;
                timer_d = '0;
                amsg_d  = msg_q;
            end
            S_WAIT_RSP: begin
                // A response in the final timer cycle beats the timeout.
                if (resp_req_out) begin
                    state_d = S_RELEASE;
                    cap_d   = auth_msg_resp_out;
                    ack_d   = 1'b1;
                end else if (timer_q == TW'(TIMEOUT_CYCLES-1)) begin
                    state_d  = S_TIMEOUT;
                    cap_d    = ERR_MSG;
                    rreset_d = 1'b1;
                    if (timeout_count != 8'hFF)
                        tcnt_d = timeout_count + 8'd1;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_RELEASE, S_TIMEOUT: begin
                state_d   = S_DELIVER;
                rsp_msg_d = cap_q;
            end
            S_DELIVER: begin
                if (rsp_ack[g_q]) begin
                    state_d  = S_IDLE;
                    rr_ptr_d = (g_q == PW'(N_REQ-1)) ? '0 : g_q + PW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        resp_req_in_d = (state_d == S_WAIT_RSP);
        busy_d        = (state_d != S_IDLE);
        rsp_valid_d   = (state_d == S_DELIVER) ? (N_REQ'(1) << g_d) : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= S_IDLE;
            rr_ptr_q         <= '0;
            g_q              <= '0;
            msg_q            <= '0;
            cap_q            <= '0;
            timer_q          <= '0;
            timeout_count    <= '0;
            req_ready        <= '0;
            rsp_valid        <= '0;
            rsp_msg          <= '0;
            resp_req_in      <= 1'b0;
            auth_msg_resp_in <= '0;
            Ack_in           <= 1'b0;
            resp_reset       <= 1'b0;
            busy             <= 1'b0;
        end else begin
            state_q          <= state_d;
            rr_ptr_q         <= rr_ptr_d;
            g_q              <= g_d;
            msg_q            <= msg_d;
            cap_q            <= cap_d;
            timer_q          <= timer_d;
            timeout_count    <= tcnt_d;
            req_ready        <= req_ready_d;
            rsp_valid        <= rsp_valid_d;
            rsp_msg          <= rsp_msg_d;
            resp_req_in      <= resp_req_in_d;
            auth_msg_resp_in <= amsg_d;
            Ack_in           <= ack_d;
            resp_reset       <= rreset_d;
            busy             <= busy_d;
        end
    end

endmodule

// File: tb/tb_auth_resp_scheduler.sv
// Self-checking bench for auth_resp_scheduler: directed table,
// reset corner cases and randomized transactions.
module tb_auth_resp_scheduler;

    localparam int N  = 3;
    localparam int ML = 64;
    localparam int TC = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid;
    logic [N*ML-1:0] req_msg;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    rsp_valid;
    logic [ML-1:0]   rsp_msg;
    logic [N-1:0]    rsp_ack;
    logic            resp_req_in;
    logic [ML-1:0]   auth_msg_resp_in;
    logic            Ack_in;
    logic            resp_reset;
    logic            resp_req_out;
    logic [ML-1:0]   auth_msg_resp_out;
    logic            busy;
    logic [7:0]      timeout_count;

    auth_resp_scheduler #(.N_REQ(N), .MSG_LEN(ML), .TIMEOUT_CYCLES(TC)) dut (
        .clk               (clk),
        .reset             (reset),
        .req_valid         (req_valid),
        .req_msg           (req_msg),
        .req_ready         (req_ready),
        .rsp_valid         (rsp_valid),
        .rsp_msg           (rsp_msg),
        .rsp_ack           (rsp_ack),
        .resp_req_in       (resp_req_in),
        .auth_msg_resp_in  (auth_msg_resp_in),
        .Ack_in            (Ack_in),
        .resp_reset        (resp_reset),
        .resp_req_out      (resp_req_out),
        .auth_msg_resp_out (auth_msg_resp_out),
        .busy              (busy),
        .timeout_count     (timeout_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] vmask;
        int           delay;   // 0 = silent responder
        bit           wrong_ack;
        int           abort;   // 1 = reset in WAIT_RSP, 2 = reset in DELIVER
        int           exp_g;
        bit           exp_to;
    } vec_t;

    int checks   = 0;
    int failures = 0;
    int m_ptr    = 0;
    int m_tc     = 0;
    logic [ML-1:0] pm [N];
    vec_t tbl [15];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int pick(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++)
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    function automatic logic [ML-1:0] err_msg();
        logic [ML-1:0] m;
        m = '0;
        m[63:32] = {8'd1, 8'd127, 8'd4, 8'd0};
        return m;
    endfunction

    task automatic chk_rst(input string tag);
        chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        chk({tag, "_rsp_msg"}, rsp_msg, 64'd0);
        chk({tag, "_resp_req_in"}, 64'(resp_req_in), 64'd0);
        chk({tag, "_amsg_in"}, auth_msg_resp_in, 64'd0);
        chk({tag, "_ack_in"}, 64'(Ack_in), 64'd0);
        chk({tag, "_resp_reset"}, 64'(resp_reset), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_tcount"}, 64'(timeout_count), 64'd0);
    endtask

    task automatic do_reset(input string tag);
        reset        = 1'b1;
        req_valid    = '0;
        rsp_ack      = '0;
        resp_req_out = 1'b0;
        tick();
        reset = 1'b0;
        chk_rst(tag);
        m_ptr = 0;
        m_tc  = 0;
    endtask

    task automatic run_txn(input vec_t v);
        logic [N-1:0]  oh;
        logic [ML-1:0] r, exp_rsp;
        int c, exp_c;
        bit hit;
        oh = N'(1) << v.exp_g;
        for (int i = 0; i < N; i++) begin
            pm[i] = {8'd1, 8'd129, 8'd0, 8'd0, $urandom};
            req_msg[i*ML +: ML] = pm[i];
        end
        req_valid = v.vmask;
        tick();
        chk("grant", 64'(req_ready), 64'(oh));
        chk("busy_on", 64'(busy), 64'd1);
        req_valid = req_valid & ~oh;
        tick();
        chk("ready_drop", 64'(req_ready), 64'd0);
        chk("issue_req", 64'(resp_req_in), 64'd1);
        chk("issue_msg", auth_msg_resp_in, pm[v.exp_g]);
        if (v.abort == 1) begin
            do_reset("rst_wait");
            return;
        end
        r   = {$urandom, $urandom};
        hit = 1'b0;
        for (c = 1; c <= TC + 2; c++) begin
            resp_req_out      = (c == v.delay);
            auth_msg_resp_out = r;
            tick();
            resp_req_out = 1'b0;
            if (Ack_in || resp_reset) begin
                hit = 1'b1;
                break;
            end
        end
        chk("event_seen", 64'(hit), 64'd1);
        if (!hit) return;
        exp_c = v.exp_to ? TC : v.delay;
        chk("event_cycle", 64'(c), 64'(exp_c));
        chk("resp_reset", 64'(resp_reset), 64'(v.exp_to));
        chk("ack_in", 64'(Ack_in), 64'(!v.exp_to));
        chk("req_in_drop", 64'(resp_req_in), 64'd0);
        if (v.exp_to) begin
            m_tc    = (m_tc == 255) ? 255 : m_tc + 1;
            exp_rsp = err_msg();
        end else begin
            exp_rsp = r;
        end
        chk("tcount", 64'(timeout_count), 64'(m_tc));
        tick();
        chk("pulse_end", 64'({Ack_in, resp_reset}), 64'd0);
        chk("rsp_valid", 64'(rsp_valid), 64'(oh));
        chk("rsp_msg", rsp_msg, exp_rsp);
        if (v.abort == 2) begin
            do_reset("rst_deliver");
            return;
        end
        if (v.wrong_ack) begin
            rsp_ack = ~oh;
            tick();
            tick();
            rsp_ack = '0;
            chk("wrong_ack_hold", 64'(rsp_valid), 64'(oh));
        end
        repeat ($urandom_range(0, 2)) tick();
        rsp_ack = oh;
        tick();
        rsp_ack = '0;
        chk("busy_off", 64'(busy), 64'd0);
        chk("rsp_drop", 64'(rsp_valid), 64'd0);
        m_ptr = (v.exp_g + 1) % N;
    endtask

    initial begin
        vec_t v;
        req_msg           = '0;
        auth_msg_resp_out = '0;
        reset             = 1'b1;
        req_valid         = '0;
        rsp_ack           = '0;
        resp_req_out      = 1'b0;

        tbl[0]  = '{3'b001,  5, 1'b0, 0, 0, 1'b0};
        tbl[1]  = '{3'b100,  3, 1'b0, 0, 2, 1'b0};
        tbl[2]  = '{3'b011,  4, 1'b0, 0, 0, 1'b0};
        tbl[3]  = '{3'b011,  7, 1'b0, 0, 1, 1'b0};
        tbl[4]  = '{3'b011,  1, 1'b0, 0, 0, 1'b0};
        tbl[5]  = '{3'b011,  2, 1'b0, 0, 1, 1'b0};
        tbl[6]  = '{3'b011,  6, 1'b0, 0, 0, 1'b0};
        tbl[7]  = '{3'b010,  0, 1'b0, 0, 1, 1'b1};
        tbl[8]  = '{3'b111, 16, 1'b0, 0, 2, 1'b0};
        tbl[9]  = '{3'b001,  2, 1'b1, 0, 0, 1'b0};
        tbl[10] = '{3'b110,  0, 1'b0, 0, 1, 1'b1};
        tbl[11] = '{3'b011,  3, 1'b0, 1, 0, 1'b0};
        tbl[12] = '{3'b011,  5, 1'b0, 0, 0, 1'b0};
        tbl[13] = '{3'b010,  4, 1'b0, 2, 1, 1'b0};
        tbl[14] = '{3'b011,  2, 1'b0, 0, 0, 1'b0};

        tick();
        do_reset("rst_init");

        for (int i = 0; i < 15; i++) run_txn(tbl[i]);

        for (int i = 0; i < 40; i++) begin
            v.vmask     = N'($urandom_range(1, (1 << N) - 1));
            v.delay     = $urandom_range(0, TC + 2);
            v.wrong_ack = 1'($urandom_range(0, 1));
            v.abort     = 0;
            v.exp_to    = (v.delay == 0) || (v.delay > TC);
            v.exp_g     = pick(v.vmask, m_ptr);
            run_txn(v);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/auth_resp_scheduler.md
# auth_resp_scheduler

Sequencer and round-robin arbiter that shares a single authentication `responder` instance among `N_REQ` requesting ports (e.g. several Type-C ports on one controller). It accepts one request message at a time, drives the responder's request/acknowledge handshake, and returns the response to the granted port. It supervises the responder with a response timeout, resetting it and synthesising an `ERROR/Unspecified` message on expiry.

## Interface
- `N_REQ`, 2: number of requesting ports (2..8).
- `MSG_LEN`, `` `MSG_LEN ``: message width, header (4 × 8-bit vars, MSB-first) plus payload.
- `TIMEOUT_CYCLES`, 1024: maximum cycles from issue to `resp_req_out`.

Ports (clock and reset first):
- `clk` in 1: single clock; all logic on posedge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in N_REQ: port i has a request pending; held until `req_ready[i]`.
- `req_msg` in N_REQ*MSG_LEN: port i message at `[i*MSG_LEN +: MSG_LEN]`.
- `req_ready` out N_REQ: one-cycle accept pulse; message latched that cycle.
- `rsp_valid` out N_REQ: response available for port i; held until `rsp_ack[i]`.
- `rsp_msg` out MSG_LEN: shared response bus, valid while any `rsp_valid` bit is high.
- `rsp_ack` in N_REQ: port i consumed the response.
- `resp_req_in` out 1: request to responder.
- `auth_msg_resp_in` out MSG_LEN: message to responder.
- `Ack_in` out 1: one-cycle acknowledge to responder.
- `resp_reset` out 1: one-cycle responder reset on timeout.
- `resp_req_out` in 1: responder response valid.
- `auth_msg_resp_out` in MSG_LEN: responder response.
- `busy` out 1: high in every state except IDLE.
- `timeout_count` out 8: saturating count of timeouts since reset.

## Operation
- States: IDLE, ISSUE, WAIT_RSP, RELEASE, TIMEOUT, DELIVER.
- IDLE: if any `req_valid`, grant the first set bit at or after `rr_ptr` (wrapping). Pulse `req_ready[g]`, latch `req_msg[g]` and `g`, go ISSUE.
- ISSUE: drive `resp_req_in`=1 with the latched message, clear the timer, go WAIT_RSP.
- WAIT_RSP: hold `resp_req_in` and the message. Timer increments each cycle.
  - On `resp_req_out`=1: capture `auth_msg_resp_out`, go RELEASE.
  - Else, when timer = TIMEOUT_CYCLES-1: go TIMEOUT.
  - If both occur in the same cycle, the response wins.
- RELEASE: `resp_req_in`=0, `Ack_in`=1 for exactly one cycle, go DELIVER.
- TIMEOUT: `resp_req_in`=0, `resp_reset`=1 for one cycle, `timeout_count` += 1 (saturates at 255). Response becomes {8'd1, 8'd127 (ERROR), 8'd4 (Unspecified), 8'd0, payload 0}. Go DELIVER.
- DELIVER: `rsp_valid[g]`=1, `rsp_msg`=captured response. On `rsp_ack[g]`: set `rr_ptr`=(g+1) mod N_REQ, go IDLE. `rsp_ack` on other bits is ignored.
- Only one transaction is in flight. Ports that are not granted stay pending without error.
- `req_valid` is sampled only in IDLE. A port re-asserting it in the `rsp_ack` cycle is arbitrated on the next IDLE cycle.
- Mid-operation reset: transaction dropped, no response delivered, `rr_ptr`=0.

## Timing
- Reset values: `req_ready`=0, `rsp_valid`=0, `rsp_msg`=0, `resp_req_in`=0, `auth_msg_resp_in`=0, `Ack_in`=0, `resp_reset`=0, `busy`=0, `timeout_count`=0. State IDLE, `rr_ptr`=0.
- All outputs are registered.
- `req_valid` to `req_ready`: 1 cycle. `req_ready` to `resp_req_in` high: 1 cycle.
- `resp_req_out` to `Ack_in` pulse: 1 cycle. `Ack_in` to `rsp_valid`: 1 cycle.
- `rsp_ack` to next `req_ready`: minimum 2 cycles (back in IDLE, then grant).
- The timeout fires exactly TIMEOUT_CYCLES cycles after `resp_req_in` first rises.

## Structure
- Add to `Parameters.v`: `` `MSG_TYPE_ERROR `` (127), error codes (Invalid Request 1, Unsupported Protocol 2, Busy 3, Unspecified 4), `` `SIZE_OF_STATES_SCHED ``, one-hot state encodings, and the default `` `AUTH_TIMEOUT_CYCLES ``.
- Sub-module `rr_arbiter`: purely combinational N_REQ-wide rotate-priority pick from (`req_valid`, `rr_ptr`) to one-hot grant plus index. The FSM, timer and capture registers live in the top.

## Test plan
- Single request: port 0 sends header {1,129,0,0} and the responder answers after 5 cycles. Required: `req_ready[0]` 1 cycle after `req_valid`; `Ack_in` pulses once; `rsp_valid[0]` with the exact response; `busy` drops after `rsp_ack`.
- Fairness: ports 0 and 1 continuously valid for 4 transactions. Required: grant order 0,1,0,1 and `rr_ptr` wraps.
- Timeout with TIMEOUT_CYCLES=16 and a silent responder. Required: `resp_reset` pulses exactly 16 cycles after `resp_req_in` rises; `rsp_msg` header is {1,127,4,0}; `timeout_count`=1.
- Response arriving on the last timer cycle. Required: the real response is delivered, no `resp_reset`, `timeout_count` unchanged.
- Reset asserted in WAIT_RSP and in DELIVER. Required: next cycle all outputs are at reset values and no `rsp_valid`; a following request is granted to port 0 first.
- Wrong-port `rsp_ack[1]` while delivering to port 0. Required: ignored, `rsp_valid[0]` stays high until `rsp_ack[0]`.
